// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction memory block.
package instr_mem_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 32;
  localparam int IDX_W  = ADDR_W - 2;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [WORD_W-1:0] FAULT_WORD = '0;

  // Byte address to word index; the two byte-offset bits are dropped.
  function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:2];
  endfunction

endpackage

// File: rtl/instr_mem_array.sv
// DEPTH x WORD_W storage: synchronous write, asynchronous read.
// A write and a read of the same word on one edge return the old word.
module instr_mem_array
  import instr_mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Storage update; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_mem.sv
// Slow instruction memory: every miss stalls the fetcher via busywait for
// LATENCY+1 cycles, then presents the word for one RESP cycle.
// Optional single-entry last-word buffer enabled by INSTR_MEM_HIT_BUF_EN.
module instr_mem
  import instr_mem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  output logic              busywait,
  output logic [WORD_W-1:0] instruction,
  output logic              fault,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data
);

  localparam int                AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0]  DEPTH_IDX = IDX_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(LATENCY - 1);

  state_e            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  rd_idx, wr_idx;
  logic              wr_in_range, idx_in_range;
  logic              hit, req_miss, fetch_done;
  logic [WORD_W-1:0] arr_rdata;
  logic              unused_addr_lsbs;

  // Byte-offset bits carry no information for a word memory.
  assign unused_addr_lsbs = ^{address[1:0], wr_addr[1:0]};

  // Range checks use the full 30-bit index so high addresses never alias.
  assign rd_idx       = word_index(address);
  assign wr_idx       = word_index(wr_addr);
  assign wr_in_range  = wr_idx < DEPTH_IDX;
  assign idx_in_range = idx_q < DEPTH_IDX;

  assign req_miss   = (state == IDLE) && read && !hit;
  assign fetch_done = (state == BUSY) && (cnt == '0);

  instr_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (wr_en && wr_in_range),
    .waddr (wr_idx[AW-1:0]),
    .wdata (wr_data),
    .raddr (idx_q[AW-1:0]),
    .rdata (arr_rdata)
  );

`ifdef INSTR_MEM_HIT_BUF_EN
  logic             buf_vld;
  logic [IDX_W-1:0] buf_idx;

  assign hit = (state == IDLE) && read && buf_vld && (rd_idx == buf_idx);

  // Last-word buffer: tracks the index whose word currently sits in
  // `instruction`. A write landing on the response edge itself leaves the
  // returned (old) word stale, so the entry is not validated then.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_vld <= 1'b0;
      buf_idx <= '0;
    end else if (fetch_done) begin
      buf_idx <= idx_q;
      buf_vld <= idx_in_range && !(wr_en && (wr_idx == idx_q));
    end else if (wr_en && (wr_idx == buf_idx)) begin
      buf_vld <= 1'b0;
    end
  end
`else
  assign hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; read is ignored outside IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_miss)   state_nxt = BUSY;
      BUSY:    if (fetch_done) state_nxt = RESP;
      RESP:                    state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Stall output: new miss in IDLE, or any countdown cycle.
  always_comb begin
    busywait = req_miss || (state == BUSY);
  end

  // Countdown and captured word index for the fetch in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      idx_q <= '0;
    end else if (req_miss) begin
      cnt   <= CNT_INIT;
      idx_q <= rd_idx;
    end else if ((state == BUSY) && (cnt != '0)) begin
      cnt   <= cnt - 1'b1;
    end
  end

  // Response registers: load on the final BUSY edge, fault lasts for RESP only.
  always_ff @(posedge clk) begin
    if (reset) begin
      instruction <= FAULT_WORD;
      fault       <= 1'b0;
    end else if (fetch_done) begin
      if (idx_in_range) begin
        instruction <= arr_rdata;
        fault       <= 1'b0;
      end else begin
        instruction <= FAULT_WORD;
        fault       <= 1'b1;
      end
    end else if (state == RESP) begin
      fault <= 1'b0;
    end
  end

endmodule
